// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider: one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN to honour the sign input; otherwise every operation is unsigned.
module div32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        dz_q, dz_d;

  logic [31:0] dvd_q, dvd_d;
  logic [31:0] prem_q, prem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] x_q, x_d;

  logic        accept;
  logic [32:0] shifted;
  logic [33:0] sub;
  logic        borrow;
  logic        unused_sub_bit;
  logic [31:0] x_mag, y_mag;
  logic [31:0] quo_fin, rem_fin;

  assign accept         = in_valid && (state_q == IDLE);
  assign shifted        = {prem_q, dvd_q[31]};
  assign sub            = {1'b0, shifted} - {2'b00, dvs_q};
  assign borrow         = sub[33];
  assign unused_sub_bit = sub[32];

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  always_comb begin
    x_mag     = magnitude(x, sign);
    y_mag     = magnitude(y, sign);
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      neg_quo_d = sign && (x[31] ^ y[31]);
      neg_rem_d = sign && x[31];
    end
    quo_fin = cond_negate(dvd_q, neg_quo_q);
    rem_fin = cond_negate(prem_q, neg_rem_q);
  end

  always_ff @(posedge clk) begin
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end
`else
  logic unused_sign;
  assign unused_sign = sign;

  always_comb begin
    x_mag   = x;
    y_mag   = y;
    quo_fin = dvd_q;
    rem_fin = prem_q;
  end
`endif

  // Datapath: operands captured on accept, then one restoring step per CALC cycle.
  always_comb begin
    dvd_d  = dvd_q;
    prem_d = prem_q;
    dvs_d  = dvs_q;
    x_d    = x_q;
    if (accept) begin
      dvd_d  = x_mag;
      prem_d = 32'd0;
      dvs_d  = y_mag;
      x_d    = x;
    end else if (state_q == CALC && cnt_q < 6'd32) begin
      if (borrow) begin
        prem_d = shifted[31:0];
        dvd_d  = {dvd_q[30:0], 1'b0};
      end else begin
        prem_d = sub[31:0];
        dvd_d  = {dvd_q[30:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    dvd_q  <= dvd_d;
    prem_q <= prem_d;
    dvs_q  <= dvs_d;
    x_q    <= x_d;
  end

  // Control: CALC spends 32 iterations plus one cycle to publish the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = 6'd0;
        end
      end
      CALC: begin
        if (dvs_q == 32'd0) begin
          state_d = DONE;
          quo_d   = 32'hFFFF_FFFF;
          rem_d   = x_q;
          dz_d    = 1'b1;
        end else if (cnt_q == 6'd32) begin
          state_d = DONE;
          quo_d   = quo_fin;
          rem_d   = rem_fin;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quo       = quo_q;
  assign rem       = rem_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: a cycle-level arithmetic model checked every cycle, plus literal results.
module tb_div32_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dz;

  int n_cmp = 0;
  int n_err = 0;

  div32_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sign(sign), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer division on widened operands.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic d);
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; d = 1'b1;
    end else begin
      d = 1'b0;
`ifdef DIV_SIGNED_EN
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
`else
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
      if (s) la = la;
`endif
      lq = la / lb;
      lr = la % lb;
      q = lq[31:0];
      r = lr[31:0];
    end
  endtask

  // Timing model: 0 idle, 1 busy (counting down to the result), 2 result presented.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_q, m_r;
  logic        m_dz;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quo", quo, 32'd0);
      chk("rst_rem", rem, 32'd0);
      chk("rst_dz", {31'd0, dz}, 32'd0);
      m_phase = 0;
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
      if (m_phase == 2) begin
        chk("quo", quo, m_q);
        chk("rem", rem, m_r);
        chk("dz", {31'd0, dz}, {31'd0, m_dz});
      end
      case (m_phase)
        0: if (in_valid) begin
          model(x, y, sign, m_q, m_r, m_dz);
          m_left  = (y == 32'd0) ? 1 : 33;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic ed,
                        input int elat, input int hold, input bit imm);
    int lat;
    if (!imm) begin
      @(posedge clk); #1;
    end
    x = a; y = b; sign = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom; y = $urandom; sign = ~s;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_quo"}, quo, eq);
    chk({nm, "_rem"}, rem, er);
    chk({nm, "_dz"}, {31'd0, dz}, {31'd0, ed});
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; sign = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 0, 1'b1);
`ifdef DIV_SIGNED_EN
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0, 1'b0);
    do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 0, 1'b0);
    do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 0, 1'b0);
`else
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 0, 1'b0);
    do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 33, 0, 1'b0);
    do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 33, 0, 1'b0);
`endif
    do_div("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, 1'b0);
    do_div("s_neg_0", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, 3, 1'b0);
    do_div("hold10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, 10, 1'b0);
    do_div("max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0, 1'b0);
    do_div("u3_5", 32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 1'b0, 33, 0, 1'b0);
    do_div("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 33, 2, 1'b0);

    // Abort a division mid-flight; no result may ever appear for it.
    @(posedge clk); #1;
    x = 32'd100; y = 32'd7; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_div("after_abort_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, 0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
